// File: rtl/conv_addr_sequencer.sv
// ---------------------------------------------------------------------------
// conv_addr_sequencer
//
// Purpose:
//   Control stage that sits directly in front of PE_Group_System. It runs a
//   1-D convolution tile by tile and produces all of the address streams and
//   strobes that stage needs:
//     load weights -> load input window -> compute O outputs ->
//     drain accumulator pipeline -> store outputs.
//   The job is launched by a start/done handshake.
//   Off-chip reads have a fixed latency of one cycle. Each on-chip buffer
//   write therefore lands one cycle after its matching off-chip read address.
//
// Optional feature (compile-time macro SEQ_WEIGHT_RELOAD_EN):
//   defined   - every tile begins with a fresh weight load (LOAD_W).
//   undefined - weights are loaded once per job and kept for later tiles.
//
// Ports:
//   clk          in   rising-edge clock
//   aclr         in   asynchronous reset, active low
//   start        in   begin a job (only looked at while idle)
//   tile_count   in   number of tiles in the job, captured with start
//   W_Base       in   off-chip weight base address, captured with start
//   I_Base       in   off-chip input base address, captured with start
//   O_Base       in   off-chip output base address, captured with start
//   busy         out  sequencer is not idle
//   done         out  one-cycle pulse when the job finishes
//   OFF_W_RAddr  out  off-chip weight read address
//   OFF_I_RAddr  out  off-chip input read address
//   OFF_O_WEn    out  off-chip output write enable
//   OFF_O_WAddr  out  off-chip output write address
//   ON_W_WEn     out  on-chip weight buffer write enable
//   ON_I_WEn     out  on-chip input buffer write enable
//   ON_W_WAddr   out  on-chip weight buffer write address
//   ON_I_WAddr   out  on-chip input buffer write address
//   ON_W_RAddr   out  on-chip weight buffer read address
//   ON_I_RAddr   out  on-chip input buffer read address
//   ON_O_RAddr   out  on-chip output buffer read address
//   pe_valid     out  PE operands valid
//   pe_first     out  first MAC of an output
//   pe_last      out  last MAC of an output
// ---------------------------------------------------------------------------
module conv_addr_sequencer #(
   parameter int AddressWidth        = 32,
   parameter int BufferWidth         = 4,
   parameter int W_PEGroupSize       = 4,
   parameter int O_PEGroupSize       = 4,
   parameter int I_PEGroupSize       = W_PEGroupSize + O_PEGroupSize - 1,
   parameter int ACC_Pipeline_Stages = 7,
   parameter int TileCountWidth      = 16
) (
   input  logic                      clk,
   input  logic                      aclr,
   input  logic                      start,
   input  logic [TileCountWidth-1:0] tile_count,
   input  logic [AddressWidth-1:0]   W_Base,
   input  logic [AddressWidth-1:0]   I_Base,
   input  logic [AddressWidth-1:0]   O_Base,
   output logic                      busy,
   output logic                      done,
   output logic [AddressWidth-1:0]   OFF_W_RAddr,
   output logic [AddressWidth-1:0]   OFF_I_RAddr,
   output logic                      OFF_O_WEn,
   output logic [AddressWidth-1:0]   OFF_O_WAddr,
   output logic                      ON_W_WEn,
   output logic                      ON_I_WEn,
   output logic [BufferWidth-1:0]    ON_W_WAddr,
   output logic [BufferWidth-1:0]    ON_I_WAddr,
   output logic [BufferWidth-1:0]    ON_W_RAddr,
   output logic [BufferWidth-1:0]    ON_I_RAddr,
   output logic [BufferWidth-1:0]    ON_O_RAddr,
   output logic                      pe_valid,
   output logic                      pe_first,
   output logic                      pe_last
);

   localparam int W = W_PEGroupSize;
   localparam int O = O_PEGroupSize;
   localparam int I = I_PEGroupSize;
   localparam int D = ACC_Pipeline_Stages;

   // The phase counter must hold the largest terminal value of any phase:
   // I (LOAD_I runs I+1 cycles), O (STORE runs O+1 cycles) or D-1 (DRAIN).
   localparam int MaxA      = (I > O) ? I : O;
   localparam int MaxCnt    = (MaxA > D) ? MaxA : D;
   localparam int CntWidth  = (MaxCnt < 1) ? 1 : $clog2(MaxCnt + 1);
   localparam int OIdxWidth = (O > 1) ? $clog2(O) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_I,
      COMPUTE,
      DRAIN,
      STORE,
      DONE
   } state_t;

   state_t                    state_q,   state_d;
   logic [CntWidth-1:0]       cnt_q,     cnt_d;
   logic [OIdxWidth-1:0]      oIdx_q,    oIdx_d;
   logic [TileCountWidth-1:0] tile_q,    tile_d;
   logic [AddressWidth-1:0]   tileOff_q, tileOff_d;
   logic [TileCountWidth-1:0] tCount_q,  tCount_d;
   logic [AddressWidth-1:0]   wBase_q,   wBase_d;
   logic [AddressWidth-1:0]   iBase_q,   iBase_d;
   logic [AddressWidth-1:0]   oBase_q,   oBase_d;
   logic [TileCountWidth:0]   tileNext;

   logic                      busy_q,      busy_d;
   logic                      done_q,      done_d;
   logic [AddressWidth-1:0]   offWRAddr_q, offWRAddr_d;
   logic [AddressWidth-1:0]   offIRAddr_q, offIRAddr_d;
   logic                      offOWEn_q,   offOWEn_d;
   logic [AddressWidth-1:0]   offOWAddr_q, offOWAddr_d;
   logic                      onWWEn_q,    onWWEn_d;
   logic                      onIWEn_q,    onIWEn_d;
   logic [BufferWidth-1:0]    onWWAddr_q,  onWWAddr_d;
   logic [BufferWidth-1:0]    onIWAddr_q,  onIWAddr_d;
   logic [BufferWidth-1:0]    onWRAddr_q,  onWRAddr_d;
   logic [BufferWidth-1:0]    onIRAddr_q,  onIRAddr_d;
   logic [BufferWidth-1:0]    onORAddr_q,  onORAddr_d;
   logic                      peValid_q,   peValid_d;
   logic                      peFirst_q,   peFirst_d;
   logic                      peLast_q,    peLast_d;

   // One extra bit lets the tile index be compared against tile_count
   // without wrapping when the job uses the largest possible tile count.
   assign tileNext = {1'b0, tile_q} + (TileCountWidth + 1)'(1);

   // Phase sequencing: state, phase counter, output index within COMPUTE,
   // tile index and the tile's address offset (t*O) kept as a running sum
   // so that no multiplier is needed. Job parameters are captured only in
   // IDLE, which is why a start pulse during a job has no effect.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      oIdx_d    = oIdx_q;
      tile_d    = tile_q;
      tileOff_d = tileOff_q;
      tCount_d  = tCount_q;
      wBase_d   = wBase_q;
      iBase_d   = iBase_q;
      oBase_d   = oBase_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               tCount_d  = tile_count;
               wBase_d   = W_Base;
               iBase_d   = I_Base;
               oBase_d   = O_Base;
               tile_d    = '0;
               tileOff_d = '0;
               cnt_d     = '0;
               oIdx_d    = '0;
               state_d   = (tile_count == '0) ? DONE : LOAD_W;
            end
         end

         LOAD_W: begin
            if (cnt_q == CntWidth'(W - 1)) begin
               cnt_d   = '0;
               state_d = LOAD_I;
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end

         LOAD_I: begin
            if (cnt_q == CntWidth'(I)) begin
               cnt_d   = '0;
               oIdx_d  = '0;
               state_d = COMPUTE;
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end

         COMPUTE: begin
            if (cnt_q == CntWidth'(W - 1)) begin
               cnt_d = '0;
               if (oIdx_q == OIdxWidth'(O - 1)) begin
                  oIdx_d  = '0;
                  state_d = DRAIN;
               end else begin
                  oIdx_d = oIdx_q + OIdxWidth'(1);
               end
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end

         DRAIN: begin
            if (cnt_q == CntWidth'(D - 1)) begin
               cnt_d   = '0;
               state_d = STORE;
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end

         STORE: begin
            if (cnt_q == CntWidth'(O)) begin
               cnt_d     = '0;
               tile_d    = tileNext[TileCountWidth-1:0];
               tileOff_d = tileOff_q + AddressWidth'(O);
               if (tileNext < {1'b0, tCount_q}) begin
`ifdef SEQ_WEIGHT_RELOAD_EN
                  state_d = LOAD_W;
`else
                  state_d = LOAD_I;
`endif
               end else begin
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output next-values. Read-side addresses and PE strobes come from the
   // upcoming state, so the registered outputs line up with the state they
   // belong to. Write-side enables come from the current state: the data
   // for a read issued this cycle returns next cycle, so the matching
   // buffer write is registered one cycle behind its read. Addresses hold
   // their last value outside their phase; enables and strobes drop to 0.
   always_comb begin
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
      offWRAddr_d = offWRAddr_q;
      offIRAddr_d = offIRAddr_q;
      offOWAddr_d = offOWAddr_q;
      onWWAddr_d  = onWWAddr_q;
      onIWAddr_d  = onIWAddr_q;
      onWRAddr_d  = onWRAddr_q;
      onIRAddr_d  = onIRAddr_q;
      onORAddr_d  = onORAddr_q;
      offOWEn_d   = 1'b0;
      onWWEn_d    = 1'b0;
      onIWEn_d    = 1'b0;
      peValid_d   = 1'b0;
      peFirst_d   = 1'b0;
      peLast_d    = 1'b0;

      case (state_d)
         LOAD_W: begin
            offWRAddr_d = wBase_d + AddressWidth'(cnt_d);
         end

         LOAD_I: begin
            if (cnt_d < CntWidth'(I)) begin
               offIRAddr_d = iBase_d + tileOff_d + AddressWidth'(cnt_d);
            end
         end

         COMPUTE: begin
            onWRAddr_d = BufferWidth'(cnt_d);
            onIRAddr_d = BufferWidth'(oIdx_d) + BufferWidth'(cnt_d);
            onORAddr_d = BufferWidth'(oIdx_d);
            peValid_d  = 1'b1;
            peFirst_d  = (cnt_d == '0);
            peLast_d   = (cnt_d == CntWidth'(W - 1));
         end

         STORE: begin
            if (cnt_d < CntWidth'(O)) begin
               onORAddr_d = BufferWidth'(cnt_d);
            end
         end

         default: begin
         end
      endcase

      if (state_q == LOAD_W) begin
         onWWEn_d   = 1'b1;
         onWWAddr_d = BufferWidth'(cnt_q);
      end

      if ((state_q == LOAD_I) && (cnt_q < CntWidth'(I))) begin
         onIWEn_d   = 1'b1;
         onIWAddr_d = BufferWidth'(cnt_q);
      end

      if ((state_q == STORE) && (cnt_q < CntWidth'(O))) begin
         offOWEn_d   = 1'b1;
         offOWAddr_d = oBase_q + tileOff_q + AddressWidth'(cnt_q);
      end
   end

   // State and output registers. Reset is asynchronous so that every output
   // and all captured job parameters clear at once, even in the middle of
   // a job.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         oIdx_q      <= '0;
         tile_q      <= '0;
         tileOff_q   <= '0;
         tCount_q    <= '0;
         wBase_q     <= '0;
         iBase_q     <= '0;
         oBase_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         offWRAddr_q <= '0;
         offIRAddr_q <= '0;
         offOWEn_q   <= 1'b0;
         offOWAddr_q <= '0;
         onWWEn_q    <= 1'b0;
         onIWEn_q    <= 1'b0;
         onWWAddr_q  <= '0;
         onIWAddr_q  <= '0;
         onWRAddr_q  <= '0;
         onIRAddr_q  <= '0;
         onORAddr_q  <= '0;
         peValid_q   <= 1'b0;
         peFirst_q   <= 1'b0;
         peLast_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         oIdx_q      <= oIdx_d;
         tile_q      <= tile_d;
         tileOff_q   <= tileOff_d;
         tCount_q    <= tCount_d;
         wBase_q     <= wBase_d;
         iBase_q     <= iBase_d;
         oBase_q     <= oBase_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         offWRAddr_q <= offWRAddr_d;
         offIRAddr_q <= offIRAddr_d;
         offOWEn_q   <= offOWEn_d;
         offOWAddr_q <= offOWAddr_d;
         onWWEn_q    <= onWWEn_d;
         onIWEn_q    <= onIWEn_d;
         onWWAddr_q  <= onWWAddr_d;
         onIWAddr_q  <= onIWAddr_d;
         onWRAddr_q  <= onWRAddr_d;
         onIRAddr_q  <= onIRAddr_d;
         onORAddr_q  <= onORAddr_d;
         peValid_q   <= peValid_d;
         peFirst_q   <= peFirst_d;
         peLast_q    <= peLast_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign OFF_W_RAddr = offWRAddr_q;
   assign OFF_I_RAddr = offIRAddr_q;
   assign OFF_O_WEn   = offOWEn_q;
   assign OFF_O_WAddr = offOWAddr_q;
   assign ON_W_WEn    = onWWEn_q;
   assign ON_I_WEn    = onIWEn_q;
   assign ON_W_WAddr  = onWWAddr_q;
   assign ON_I_WAddr  = onIWAddr_q;
   assign ON_W_RAddr  = onWRAddr_q;
   assign ON_I_RAddr  = onIRAddr_q;
   assign ON_O_RAddr  = onORAddr_q;
   assign pe_valid    = peValid_q;
   assign pe_first    = peFirst_q;
   assign pe_last     = peLast_q;

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_addr_sequencer
//
// Purpose:
//   Self-checking bench for conv_addr_sequencer with default parameters
//   (W=O=4, I=7, D=7). Each job is launched with a start pulse, every
//   output is recorded per cycle (cycle 1 is the cycle after the edge that
//   samples start) and the recording is compared with hand-computed
//   expectations. Honours SEQ_WEIGHT_RELOAD_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_conv_addr_sequencer;

`ifdef SEQ_WEIGHT_RELOAD_EN
   localparam int Reload = 4;
`else
   localparam int Reload = 0;
`endif

   localparam int NF = 16;
   localparam int F_BUSY = 0, F_DONE = 1, F_OWR = 2, F_OIR = 3, F_OOWEN = 4,
                  F_OOWA = 5, F_WWEN = 6, F_IWEN = 7, F_WWA = 8, F_IWA = 9,
                  F_WRA = 10, F_IRA = 11, F_ORA = 12, F_PEV = 13, F_PEF = 14,
                  F_PEL = 15;

   string fieldNames [NF] = '{"busy", "done", "OFF_W_RAddr", "OFF_I_RAddr",
                              "OFF_O_WEn", "OFF_O_WAddr", "ON_W_WEn",
                              "ON_I_WEn", "ON_W_WAddr", "ON_I_WAddr",
                              "ON_W_RAddr", "ON_I_RAddr", "ON_O_RAddr",
                              "pe_valid", "pe_first", "pe_last"};

   logic        clk = 1'b0;
   logic        aclr;
   logic        start;
   logic [15:0] tile_count;
   logic [31:0] W_Base, I_Base, O_Base;
   logic        busy, done, OFF_O_WEn, ON_W_WEn, ON_I_WEn;
   logic        pe_valid, pe_first, pe_last;
   logic [31:0] OFF_W_RAddr, OFF_I_RAddr, OFF_O_WAddr;
   logic [3:0]  ON_W_WAddr, ON_I_WAddr, ON_W_RAddr, ON_I_RAddr, ON_O_RAddr;

   logic [31:0] tr [0:127][0:NF-1];

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
   } vec_t;

   vec_t job1Tbl [$];

   int passCount  = 0;
   int totalCount = 0;

   conv_addr_sequencer dut (
      .clk         (clk),
      .aclr        (aclr),
      .start       (start),
      .tile_count  (tile_count),
      .W_Base      (W_Base),
      .I_Base      (I_Base),
      .O_Base      (O_Base),
      .busy        (busy),
      .done        (done),
      .OFF_W_RAddr (OFF_W_RAddr),
      .OFF_I_RAddr (OFF_I_RAddr),
      .OFF_O_WEn   (OFF_O_WEn),
      .OFF_O_WAddr (OFF_O_WAddr),
      .ON_W_WEn    (ON_W_WEn),
      .ON_I_WEn    (ON_I_WEn),
      .ON_W_WAddr  (ON_W_WAddr),
      .ON_I_WAddr  (ON_I_WAddr),
      .ON_W_RAddr  (ON_W_RAddr),
      .ON_I_RAddr  (ON_I_RAddr),
      .ON_O_RAddr  (ON_O_RAddr),
      .pe_valid    (pe_valid),
      .pe_first    (pe_first),
      .pe_last     (pe_last)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Hard stop in case the run never reaches its summary.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int cyc,
                              input logic [31:0] act, input logic [31:0] exp);
      totalCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s cycle %0d: got 0x%0h, required 0x%0h",
                  name, cyc, act, exp);
      end
   endtask

   task automatic takeSnap(input int c);
      tr[c][F_BUSY]  = 32'(busy);
      tr[c][F_DONE]  = 32'(done);
      tr[c][F_OWR]   = OFF_W_RAddr;
      tr[c][F_OIR]   = OFF_I_RAddr;
      tr[c][F_OOWEN] = 32'(OFF_O_WEn);
      tr[c][F_OOWA]  = OFF_O_WAddr;
      tr[c][F_WWEN]  = 32'(ON_W_WEn);
      tr[c][F_IWEN]  = 32'(ON_I_WEn);
      tr[c][F_WWA]   = 32'(ON_W_WAddr);
      tr[c][F_IWA]   = 32'(ON_I_WAddr);
      tr[c][F_WRA]   = 32'(ON_W_RAddr);
      tr[c][F_IRA]   = 32'(ON_I_RAddr);
      tr[c][F_ORA]   = 32'(ON_O_RAddr);
      tr[c][F_PEV]   = 32'(pe_valid);
      tr[c][F_PEF]   = 32'(pe_first);
      tr[c][F_PEL]   = 32'(pe_last);
   endtask

   // Launches one job and records outputs for cycles 1..nCyc. Optionally
   // pulses start again at busyStartCyc with different parameters, and
   // optionally asserts aclr at rstCyc (recording that cycle just after
   // the reset is applied and stopping there, reset left asserted).
   task automatic applyStimulus(input logic [15:0] tc, input logic [31:0] wb,
                                input logic [31:0] ib, input logic [31:0] ob,
                                input int nCyc, input int busyStartCyc,
                                input int rstCyc);
      for (int c = 0; c < 128; c++) begin
         for (int f = 0; f < NF; f++) begin
            tr[c][f] = 32'hFFFF_FFFF;
         end
      end
      @(negedge clk);
      tile_count = tc;
      W_Base     = wb;
      I_Base     = ib;
      O_Base     = ob;
      start      = 1'b1;
      for (int c = 1; c <= nCyc; c++) begin
         @(negedge clk);
         if (c == rstCyc) begin
            aclr  = 1'b0;
            start = 1'b0;
            #1;
            takeSnap(c);
            break;
         end
         takeSnap(c);
         if (c == 1) begin
            start = 1'b0;
         end
         if (c == busyStartCyc) begin
            start      = 1'b1;
            tile_count = 16'd5;
            W_Base     = 32'h900;
            I_Base     = 32'hA00;
            O_Base     = 32'hB00;
         end
         if (c == busyStartCyc + 1) begin
            start = 1'b0;
         end
      end
   endtask

   task automatic addVec(input int c, input int s, input logic [31:0] e);
      vec_t v;
      v.cyc = c;
      v.sel = s;
      v.exp = e;
      job1Tbl.push_back(v);
   endtask

   task automatic checkTable(input string tag);
      foreach (job1Tbl[i]) begin
         checkOutput($sformatf("%s %s", tag, fieldNames[job1Tbl[i].sel]),
                     job1Tbl[i].cyc, tr[job1Tbl[i].cyc][job1Tbl[i].sel],
                     job1Tbl[i].exp);
      end
   endtask

   task automatic checkDoneBusy(input string tag, input int doneCyc, input int nCyc);
      for (int c = 1; c <= nCyc; c++) begin
         checkOutput({tag, " done"}, c, tr[c][F_DONE], 32'(c == doneCyc));
         checkOutput({tag, " busy"}, c, tr[c][F_BUSY], 32'(c <= doneCyc));
      end
   endtask

   function automatic int countField(input int sel, input int nCyc);
      int n = 0;
      for (int c = 1; c <= nCyc; c++) begin
         n += int'(tr[c][sel]);
      end
      return n;
   endfunction

   initial begin
      // Job 1 expectations: tile_count=1, bases 0x100/0x200/0x300.
      addVec(1,  F_BUSY, 1);      addVec(1,  F_OWR, 32'h100);
      addVec(4,  F_OWR, 32'h103); addVec(30, F_OWR, 32'h103);
      addVec(1,  F_WWEN, 0);      addVec(2,  F_WWEN, 1);
      addVec(2,  F_WWA, 0);       addVec(5,  F_WWEN, 1);
      addVec(5,  F_WWA, 3);       addVec(6,  F_WWEN, 0);
      addVec(5,  F_OIR, 32'h200); addVec(11, F_OIR, 32'h206);
      addVec(12, F_OIR, 32'h206); addVec(5,  F_IWEN, 0);
      addVec(6,  F_IWEN, 1);      addVec(6,  F_IWA, 0);
      addVec(12, F_IWEN, 1);      addVec(12, F_IWA, 6);
      addVec(13, F_IWEN, 0);      addVec(12, F_PEV, 0);
      addVec(13, F_PEV, 1);       addVec(13, F_PEF, 1);
      addVec(13, F_PEL, 0);       addVec(13, F_IRA, 0);
      addVec(16, F_PEL, 1);       addVec(16, F_WRA, 3);
      addVec(17, F_ORA, 1);       addVec(17, F_PEF, 1);
      addVec(20, F_WRA, 3);       addVec(20, F_IRA, 4);
      addVec(20, F_ORA, 1);       addVec(20, F_PEL, 1);
      addVec(20, F_PEF, 0);       addVec(20, F_PEV, 1);
      addVec(28, F_IRA, 6);       addVec(28, F_ORA, 3);
      addVec(28, F_PEL, 1);       addVec(29, F_PEV, 0);
      addVec(29, F_PEL, 0);       addVec(29, F_ORA, 3);
      addVec(35, F_PEV, 0);       addVec(36, F_ORA, 0);
      addVec(36, F_OOWEN, 0);     addVec(37, F_OOWEN, 1);
      addVec(37, F_OOWA, 32'h300); addVec(38, F_ORA, 2);
      addVec(40, F_OOWEN, 1);     addVec(40, F_OOWA, 32'h303);
      addVec(41, F_OOWEN, 0);     addVec(40, F_DONE, 0);
      addVec(41, F_DONE, 1);      addVec(41, F_BUSY, 1);
      addVec(42, F_BUSY, 0);      addVec(42, F_DONE, 0);

      aclr       = 1'b0;
      start      = 1'b0;
      tile_count = '0;
      W_Base     = '0;
      I_Base     = '0;
      O_Base     = '0;
      repeat (2) @(negedge clk);
      takeSnap(0);
      for (int f = 0; f < NF; f++) begin
         checkOutput({"reset ", fieldNames[f]}, 0, tr[0][f], 32'h0);
      end
      aclr = 1'b1;
      @(negedge clk);

      $display("[TB] job 1: single tile");
      applyStimulus(16'd1, 32'h100, 32'h200, 32'h300, 42, -1, -1);
      checkTable("job1");
      checkDoneBusy("job1", 41, 42);
      checkOutput("job1 pe_valid count", 0, 32'(countField(F_PEV, 42)), 32'd16);
      checkOutput("job1 ON_W_WEn count", 0, 32'(countField(F_WWEN, 42)), 32'd4);
      checkOutput("job1 ON_I_WEn count", 0, 32'(countField(F_IWEN, 42)), 32'd7);
      checkOutput("job1 OFF_O_WEn count", 0, 32'(countField(F_OOWEN, 42)), 32'd4);

      $display("[TB] job 1 with start pulse while busy");
      applyStimulus(16'd1, 32'h100, 32'h200, 32'h300, 44, 10, -1);
      checkOutput("busystart OFF_I_RAddr", 11, tr[11][F_OIR], 32'h206);
      checkOutput("busystart OFF_O_WAddr", 37, tr[37][F_OOWA], 32'h300);
      checkOutput("busystart OFF_O_WAddr", 40, tr[40][F_OOWA], 32'h303);
      checkDoneBusy("busystart", 41, 44);

      $display("[TB] job 2: two tiles");
      applyStimulus(16'd2, 32'h100, 32'h200, 32'h300, 82, -1, -1);
      checkOutput("job2 OFF_I_RAddr", 41 + Reload, tr[41 + Reload][F_OIR], 32'h204);
      checkOutput("job2 OFF_I_RAddr", 47 + Reload, tr[47 + Reload][F_OIR], 32'h20A);
      checkOutput("job2 OFF_O_WEn", 73 + Reload, tr[73 + Reload][F_OOWEN], 32'h1);
      checkOutput("job2 OFF_O_WAddr", 73 + Reload, tr[73 + Reload][F_OOWA], 32'h304);
      checkOutput("job2 OFF_O_WEn", 76 + Reload, tr[76 + Reload][F_OOWEN], 32'h1);
      checkOutput("job2 OFF_O_WAddr", 76 + Reload, tr[76 + Reload][F_OOWA], 32'h307);
      checkOutput("job2 ON_W_WEn count", 0, 32'(countField(F_WWEN, 82)), 32'(4 + Reload));
      checkOutput("job2 OFF_O_WEn count", 0, 32'(countField(F_OOWEN, 82)), 32'd8);
      checkOutput("job2 pe_valid count", 0, 32'(countField(F_PEV, 82)), 32'd32);
`ifdef SEQ_WEIGHT_RELOAD_EN
      checkOutput("job2 reload OFF_W_RAddr", 41, tr[41][F_OWR], 32'h100);
      checkOutput("job2 reload OFF_W_RAddr", 44, tr[44][F_OWR], 32'h103);
      checkOutput("job2 reload ON_W_WAddr", 45, tr[45][F_WWA], 32'h3);
`else
      checkOutput("job2 held OFF_W_RAddr", 41, tr[41][F_OWR], 32'h103);
      checkOutput("job2 no reload ON_W_WEn", 42, tr[42][F_WWEN], 32'h0);
`endif
      checkDoneBusy("job2", 77 + Reload, 82);

      $display("[TB] job with tile_count=0");
      applyStimulus(16'd0, 32'h100, 32'h200, 32'h300, 3, -1, -1);
      checkDoneBusy("zero", 1, 3);
      checkOutput("zero enables", 0,
                  32'(countField(F_WWEN, 3) + countField(F_IWEN, 3) +
                      countField(F_OOWEN, 3) + countField(F_PEV, 3) +
                      countField(F_PEF, 3) + countField(F_PEL, 3)), 32'd0);

      $display("[TB] reset in the middle of job 1");
      applyStimulus(16'd1, 32'h100, 32'h200, 32'h300, 42, -1, 20);
      for (int f = 0; f < NF; f++) begin
         checkOutput({"midreset ", fieldNames[f]}, 20, tr[20][f], 32'h0);
      end
      @(negedge clk);
      aclr = 1'b1;
      @(negedge clk);
      applyStimulus(16'd1, 32'h100, 32'h200, 32'h300, 42, -1, -1);
      checkTable("afterreset");
      checkDoneBusy("afterreset", 41, 42);

      $display("[TB] %0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
